// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Receive-side controller for the 16550A-style UART. Buffers characters
//   and their error flags from the receiver shift engine in a DEPTH-entry
//   FIFO, or in a single holding register in 16450 mode. Maintains the
//   receive line status bits and raises the received-data-available and
//   character-timeout interrupt requests.
//
// Ports
//   clk, rst_n               system clock, async active-low reset
//   baud_pulse               16x oversample tick
//   rx_push, rx_data,
//   rx_pe, rx_fe, rx_bi      character-complete strobe with data and flags
//   fifo_en, fifo_clr, trig  FCR controls (mode, flush strobe, trigger level)
//   wls, pen, stb            line format, sets the character-timeout length
//   rd, lsr_rd               RBR / LSR read strobes
//   rdata, pe, fe, bi        head entry (0 when empty)
//   dr, oe, fifo_err, level  line status and fill level
//   rda_irq, cto_irq         interrupt requests
module uart_rx_ctrl #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       baud_pulse,
    input  logic                       rx_push,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_pe,
    input  logic                       rx_fe,
    input  logic                       rx_bi,
    input  logic                       fifo_en,
    input  logic                       fifo_clr,
    input  logic [1:0]                 trig,
    input  logic [1:0]                 wls,
    input  logic                       pen,
    input  logic                       stb,
    input  logic                       rd,
    input  logic                       lsr_rd,
    output logic [7:0]                 rdata,
    output logic                       dr,
    output logic                       oe,
    output logic                       pe,
    output logic                       fe,
    output logic                       bi,
    output logic                       fifo_err,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       rda_irq,
    output logic                       cto_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] err_cnt;
    logic          oe_q;
    logic          fifo_en_q;
    logic [1:0]    trig_q;
    logic [9:0]    limit_q;
    logic [9:0]    to_cnt;

    logic [10:0]   head;
    logic [10:0]   entry;
    logic          empty;
    logic          full;
    logic          flush;
    logic          do_push;
    logic          do_pop;
    logic          overwrite;
    logic          overrun;
    logic          new_err;
    logic          head_err;
    logic [LW-1:0] level_nxt;
    logic [LW-1:0] err_nxt;
    logic [3:0]    charbits;
    logic [9:0]    limit_nxt;
    logic [LW-1:0] threshold;

    assign head     = mem[rd_ptr];
    assign entry    = {rx_bi, rx_fe, rx_pe, rx_data};
    assign new_err  = rx_pe | rx_fe | rx_bi;
    assign head_err = |head[10:8];
    assign empty    = (level_q == '0);
    assign full     = fifo_en ? (level_q == LW'(DEPTH)) : (level_q == LW'(1));

    // A mode change is treated like an FCR flush so stale entries never
    // leak across the 16450/16550 boundary.
    assign flush    = fifo_clr | (fifo_en != fifo_en_q);

    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign do_pop    = rd & ~empty & ~flush;
    assign do_push   = rx_push & ~flush & (~full | do_pop);
    assign overrun   = rx_push & ~flush & full & ~do_pop;
    assign overwrite = overrun & ~fifo_en;

    assign charbits  = 4'd7 + {2'b00, wls} + {3'b000, pen} + {3'b000, stb};
    assign limit_nxt = {charbits, 6'b000000};

    always_comb begin
        level_nxt = level_q;
        if (flush)
            level_nxt = '0;
        else if (do_push && !do_pop)
            level_nxt = level_q + LW'(1);
        else if (do_pop && !do_push)
            level_nxt = level_q - LW'(1);
    end

    always_comb begin
        err_nxt = err_cnt;
        if (flush) begin
            err_nxt = '0;
        end else if (overwrite) begin
            err_nxt = err_cnt - LW'(head_err) + LW'(new_err);
        end else begin
            if (do_push && new_err)
                err_nxt = err_nxt + LW'(1);
            if (do_pop && head_err)
                err_nxt = err_nxt - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= entry;
        else if (overwrite)
            mem[rd_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            err_cnt   <= '0;
            oe_q      <= 1'b0;
            fifo_en_q <= 1'b0;
            trig_q    <= 2'b00;
            limit_q   <= '0;
            to_cnt    <= '0;
        end else begin
            fifo_en_q <= fifo_en;
            trig_q    <= trig;
            limit_q   <= limit_nxt;
            level_q   <= level_nxt;
            err_cnt   <= err_nxt;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end

            if (overrun)
                oe_q <= 1'b1;
            else if (lsr_rd)
                oe_q <= 1'b0;

            if (rx_push || rd || flush || empty)
                to_cnt <= '0;
            else if (baud_pulse && fifo_en && (to_cnt < limit_q))
                to_cnt <= to_cnt + 10'd1;
        end
    end

    always_comb begin
        case (trig_q)
            2'b00:   threshold = LW'(1);
            2'b01:   threshold = LW'(4);
            2'b10:   threshold = LW'(8);
            default: threshold = LW'(14);
        endcase
    end

    assign level    = level_q;
    assign dr       = ~empty;
    assign oe       = oe_q;
    assign rdata    = empty ? 8'h00 : head[7:0];
    assign pe       = ~empty & head[8];
    assign fe       = ~empty & head[9];
    assign bi       = ~empty & head[10];
    assign fifo_err = fifo_en_q & (err_cnt != '0);
    assign rda_irq  = fifo_en_q ? (level_q >= threshold) : ~empty;
    assign cto_irq  = fifo_en_q & ~empty & (to_cnt == limit_q);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_pulse = 1'b0;
    logic       rx_push = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_pe = 1'b0, rx_fe = 1'b0, rx_bi = 1'b0;
    logic       fifo_en = 1'b1;
    logic       fifo_clr = 1'b0;
    logic [1:0] trig = 2'b01;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       stb = 1'b0;
    logic       rd = 1'b0;
    logic       lsr_rd = 1'b0;
    logic [7:0] rdata;
    logic       dr, oe, pe, fe, bi, fifo_err, rda_irq, cto_irq;
    logic [4:0] level;

    int vectors = 0;
    int errors  = 0;

    uart_rx_ctrl #(.DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse),
        .rx_push(rx_push), .rx_data(rx_data),
        .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
        .fifo_en(fifo_en), .fifo_clr(fifo_clr), .trig(trig),
        .wls(wls), .pen(pen), .stb(stb), .rd(rd), .lsr_rd(lsr_rd),
        .rdata(rdata), .dr(dr), .oe(oe), .pe(pe), .fe(fe), .bi(bi),
        .fifo_err(fifo_err), .level(level),
        .rda_irq(rda_irq), .cto_irq(cto_irq)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic p, input logic f, input logic b);
        rx_push = 1'b1; rx_data = d; rx_pe = p; rx_fe = f; rx_bi = b;
        tick();
        rx_push = 1'b0; rx_pe = 1'b0; rx_fe = 1'b0; rx_bi = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({rdata, dr, oe, pe, fe, bi, fifo_err, level, rda_irq, cto_irq} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h dr=%b oe=%b pe=%b fe=%b bi=%b ferr=%b level=%0d rda=%b cto=%b, expected all 0",
                     rdata, dr, oe, pe, fe, bi, fifo_err, level, rda_irq, cto_irq);
        end
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_trigger();
        trig = 2'b01;
        push(8'h41, 0, 0, 0);
        push(8'h42, 0, 0, 0);
        push(8'h43, 0, 0, 0);
        vectors++;
        if (level !== 5'd3 || rda_irq !== 1'b0 || rdata !== 8'h41 || dr !== 1'b1) begin
            errors++;
            $display("FAIL trig_three: level=%0d rda=%b rdata=%h dr=%b, expected 3 0 41 1", level, rda_irq, rdata, dr);
        end
        push(8'h44, 0, 0, 0);
        vectors++;
        if (level !== 5'd4 || rda_irq !== 1'b1) begin
            errors++;
            $display("FAIL trig_four: level=%0d rda=%b, expected 4 1", level, rda_irq);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rdata !== 8'h41 + 8'(i)) begin
                errors++;
                $display("FAIL trig_read%0d: rdata=%h expected %h", i, rdata, 8'h41 + 8'(i));
            end
            pop();
        end
        vectors++;
        if (level !== 5'd0 || dr !== 1'b0 || rdata !== 8'h00 || rda_irq !== 1'b0) begin
            errors++;
            $display("FAIL trig_empty: level=%0d dr=%b rdata=%h rda=%b, expected 0 0 00 0", level, dr, rdata, rda_irq);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 17; i++) push(8'h80 + 8'(i), 0, 0, 0);
        vectors++;
        if (level !== 5'd16 || oe !== 1'b1 || rdata !== 8'h80) begin
            errors++;
            $display("FAIL ovr_full: level=%0d oe=%b rdata=%h, expected 16 1 80", level, oe, rdata);
        end
        lsr_rd = 1'b1;
        tick();
        lsr_rd = 1'b0;
        vectors++;
        if (oe !== 1'b0) begin
            errors++;
            $display("FAIL ovr_lsr_clear: oe=%b expected 0", oe);
        end
    endtask

    task automatic test_full_push_pop();
        rx_push = 1'b1; rx_data = 8'hAA; rd = 1'b1;
        tick();
        rx_push = 1'b0; rd = 1'b0;
        vectors++;
        if (level !== 5'd16 || oe !== 1'b0 || rdata !== 8'h81) begin
            errors++;
            $display("FAIL fullpp: level=%0d oe=%b rdata=%h, expected 16 0 81", level, oe, rdata);
        end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == 15) ? 8'hAA : 8'h81 + 8'(i);
            vectors++;
            if (rdata !== exp_d) begin
                errors++;
                $display("FAIL fullpp_read%0d: rdata=%h expected %h", i, rdata, exp_d);
            end
            pop();
        end
        vectors++;
        if (level !== 5'd0) begin
            errors++;
            $display("FAIL fullpp_drain: level=%0d expected 0", level);
        end
    endtask

    task automatic test_errors();
        push(8'h55, 0, 1, 0);
        push(8'h66, 0, 0, 0);
        vectors++;
        if (fifo_err !== 1'b1 || fe !== 1'b1 || pe !== 1'b0 || bi !== 1'b0 || rdata !== 8'h55) begin
            errors++;
            $display("FAIL err_head: ferr=%b fe=%b pe=%b bi=%b rdata=%h, expected 1 1 0 0 55", fifo_err, fe, pe, bi, rdata);
        end
        pop();
        vectors++;
        if (fifo_err !== 1'b0 || fe !== 1'b0 || rdata !== 8'h66) begin
            errors++;
            $display("FAIL err_after_rd: ferr=%b fe=%b rdata=%h, expected 0 0 66", fifo_err, fe, rdata);
        end
        pop();
        push(8'h11, 1, 0, 1);
        vectors++;
        if (fifo_err !== 1'b1 || pe !== 1'b1 || bi !== 1'b1 || fe !== 1'b0) begin
            errors++;
            $display("FAIL err_pe_bi: ferr=%b pe=%b bi=%b fe=%b, expected 1 1 1 0", fifo_err, pe, bi, fe);
        end
        pop();
    endtask

    task automatic test_timeout();
        wls = 2'b11; pen = 1'b1; stb = 1'b0;
        tick();
        push(8'h77, 0, 0, 0);
        for (int i = 0; i < 703; i++) begin
            baud_pulse = 1'b1;
            tick();
            baud_pulse = 1'b0;
            tick();
        end
        vectors++;
        if (cto_irq !== 1'b0) begin
            errors++;
            $display("FAIL cto_703: cto=%b expected 0", cto_irq);
        end
        baud_pulse = 1'b1;
        tick();
        baud_pulse = 1'b0;
        vectors++;
        if (cto_irq !== 1'b1) begin
            errors++;
            $display("FAIL cto_704: cto=%b expected 1", cto_irq);
        end
        for (int i = 0; i < 3; i++) begin
            baud_pulse = 1'b1;
            tick();
            baud_pulse = 1'b0;
        end
        vectors++;
        if (cto_irq !== 1'b1) begin
            errors++;
            $display("FAIL cto_saturate: cto=%b expected 1", cto_irq);
        end
        pop();
        vectors++;
        if (cto_irq !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL cto_rd: cto=%b level=%0d, expected 0 0", cto_irq, level);
        end
    endtask

    task automatic test_flush();
        push(8'h01, 0, 1, 0);
        push(8'h02, 0, 0, 0);
        fifo_clr = 1'b1; rx_push = 1'b1; rx_data = 8'h03;
        tick();
        fifo_clr = 1'b0; rx_push = 1'b0;
        vectors++;
        if (level !== 5'd0 || dr !== 1'b0 || fifo_err !== 1'b0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL flush: level=%0d dr=%b ferr=%b rdata=%h, expected 0 0 0 00", level, dr, fifo_err, rdata);
        end
        pop();
        vectors++;
        if (level !== 5'd0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL rd_empty: level=%0d rdata=%h, expected 0 00", level, rdata);
        end
        rx_push = 1'b1; rx_data = 8'h5A; rd = 1'b1;
        tick();
        rx_push = 1'b0; rd = 1'b0;
        vectors++;
        if (level !== 5'd1 || rdata !== 8'h5A) begin
            errors++;
            $display("FAIL pushrd_empty: level=%0d rdata=%h, expected 1 5a", level, rdata);
        end
        push(8'h5B, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        vectors++;
        if (level !== 5'd0 || dr !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: level=%0d dr=%b, expected 0 0", level, dr);
        end
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_16450();
        fifo_en = 1'b0;
        tick();
        tick();
        push(8'h10, 0, 0, 0);
        push(8'h20, 0, 1, 0);
        vectors++;
        if (level !== 5'd1 || rdata !== 8'h20 || oe !== 1'b1 || rda_irq !== 1'b1 || fe !== 1'b1 || fifo_err !== 1'b0) begin
            errors++;
            $display("FAIL m16450_ovw: level=%0d rdata=%h oe=%b rda=%b fe=%b ferr=%b, expected 1 20 1 1 1 0",
                     level, rdata, oe, rda_irq, fe, fifo_err);
        end
        fifo_en = 1'b1;
        tick();
        vectors++;
        if (level !== 5'd0 || oe !== 1'b1 || dr !== 1'b0) begin
            errors++;
            $display("FAIL m16450_toggle: level=%0d oe=%b dr=%b, expected 0 1 0", level, oe, dr);
        end
        tick();
        push(8'h33, 0, 0, 0);
        vectors++;
        if (fifo_err !== 1'b0 || level !== 5'd1) begin
            errors++;
            $display("FAIL m16450_errcnt: ferr=%b level=%0d, expected 0 1", fifo_err, level);
        end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_overrun();
        test_full_push_pop();
        test_errors();
        test_timeout();
        test_flush();
        test_16450();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
